// File: rtl/linear_layer_fifo_pkg.sv
// Shared sizing helpers for the Linear_Layer dataflow start-token FIFOs.
package linear_layer_fifo_pkg;

  // Bits needed to represent an occupancy of 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_legal(input int depth, input int addr_width);
    return (depth >= 1) && ((1 << addr_width) >= depth);
  endfunction

endpackage

// File: rtl/linear_layer_start_fifo_shiftreg.sv
// SRL-style token storage: newest entry at index 0, random-access read port.
module linear_layer_start_fifo_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Sized to the full address space so every addr value selects a real slot.
  localparam int SLOTS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = SLOTS - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_fifo.sv
// Show-ahead start-token FIFO between the producer and the PE_i4xi4 consumer.
module linear_layer_start_fifo
  import linear_layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int OCC_W = occ_width(DEPTH);

  if (!depth_legal(DEPTH, ADDR_WIDTH) || (OCC_W > CNT_W)) begin : g_bad_params
    $error("linear_layer_start_fifo: DEPTH/ADDR_WIDTH combination is illegal");
  end

  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] raddr_next;

  always_comb begin
    push       = if_write & if_write_ce & if_full_n;
    pop        = if_read & if_read_ce & if_empty_n;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    // Head sits at count-1; park at 0 when empty so the read path never floats.
    raddr_next = (count_next != '0) ? ADDR_WIDTH'(count_next - CNT_W'(1)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      raddr      <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      count      <= count_next;
      raddr      <= raddr_next;
      if_empty_n <= (count_next != '0);
      if_full_n  <= (count_next != CNT_W'(DEPTH));
    end
  end

  assign num_data_valid = count;

  linear_layer_start_fifo_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .addr (raddr),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule

// File: tb/tb_linear_layer_start_fifo.sv
// Directed and scoreboard checks for linear_layer_start_fifo at DEPTH 2, 4 and 1.
module tb_linear_layer_start_fifo;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DEPTH=2, DATA_WIDTH=1
  logic       w2, wce2, din2, r2, rce2, fn2, en2, dout2;
  logic [1:0] nd2;
  // DEPTH=4, DATA_WIDTH=8
  logic       w4, wce4, r4, rce4, fn4, en4;
  logic [7:0] din4, dout4;
  logic [2:0] nd4;
  // DEPTH=1, DATA_WIDTH=1
  logic       w1, wce1, din1, r1, rce1, fn1, en1, dout1;
  logic [1:0] nd1;

  linear_layer_start_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .if_full_n(fn2), .if_write_ce(wce2), .if_write(w2),
    .if_din(din2), .if_empty_n(en2), .if_read_ce(rce2), .if_read(r2),
    .if_dout(dout2), .num_data_valid(nd2));

  linear_layer_start_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .if_full_n(fn4), .if_write_ce(wce4), .if_write(w4),
    .if_din(din4), .if_empty_n(en4), .if_read_ce(rce4), .if_read(r4),
    .if_dout(dout4), .num_data_valid(nd4));

  linear_layer_start_fifo #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .if_full_n(fn1), .if_write_ce(wce1), .if_write(w1),
    .if_din(din1), .if_empty_n(en1), .if_read_ce(rce1), .if_read(r1),
    .if_dout(dout1), .num_data_valid(nd1));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic       mpush, mpop;

  initial begin
    reset = 1'b1;
    {w2, wce2, din2, r2, rce2} = '0;
    {w4, wce4, r4, rce4} = '0; din4 = '0;
    {w1, wce1, din1, r1, rce1} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en2", en2, 0); chk("rst_fn2", fn2, 1); chk("rst_nd2", nd2, 0);
    chk("rst_en4", en4, 0); chk("rst_fn4", fn4, 1); chk("rst_nd4", nd4, 0);
    chk("rst_en1", en1, 0); chk("rst_fn1", fn1, 1);
    reset = 1'b0;
    tick();
    chk("idle_en2", en2, 0); chk("idle_nd2", nd2, 0);

    // DEPTH=2: write 1 then 0
    wce2 = 1; rce2 = 1; w2 = 1; din2 = 1;
    tick();
    chk("d2_w1_nd", nd2, 1); chk("d2_w1_en", en2, 1); chk("d2_w1_dout", dout2, 1);
    din2 = 0;
    tick();
    chk("d2_w2_nd", nd2, 2); chk("d2_w2_fn", fn2, 0); chk("d2_w2_dout", dout2, 1);
    // full: write+read performs pop only
    din2 = 1; r2 = 1;
    tick();
    chk("d2_full_nd", nd2, 1); chk("d2_full_fn", fn2, 1); chk("d2_full_dout", dout2, 0);
    r2 = 0;
    tick();
    chk("d2_held_nd", nd2, 2); chk("d2_held_fn", fn2, 0); chk("d2_held_dout", dout2, 0);
    w2 = 0; r2 = 1;
    tick();
    chk("d2_pop1_nd", nd2, 1); chk("d2_pop1_dout", dout2, 1);
    tick();
    chk("d2_pop2_nd", nd2, 0); chk("d2_pop2_en", en2, 0);
    tick();
    chk("d2_underflow_nd", nd2, 0);
    r2 = 0; w2 = 1; wce2 = 0; din2 = 1;
    tick();
    chk("d2_wce_gate_nd", nd2, 0);
    wce2 = 1; din2 = 1;
    tick();
    din2 = 0;
    tick();
    w2 = 0;
    chk("d2_pre_rst_nd", nd2, 2);
    reset = 1'b1;
    #1;
    chk("d2_async_nd", nd2, 0); chk("d2_async_en", en2, 0); chk("d2_async_fn", fn2, 1);
    #1;
    reset = 1'b0;
    w2 = 1; din2 = 1;
    tick();
    chk("d2_post_rst_nd", nd2, 1); chk("d2_post_rst_dout", dout2, 1);
    w2 = 0; r2 = 1;
    tick();
    chk("d2_post_rst_empty", en2, 0);
    r2 = 0;

    // DEPTH=4: simultaneous push/pop with one entry
    wce4 = 1; rce4 = 1; w4 = 1; din4 = 8'hA5;
    tick();
    chk("d4_a5_dout", dout4, 8'hA5);
    din4 = 8'h3C; r4 = 1;
    tick();
    chk("d4_pp_nd", nd4, 1); chk("d4_pp_dout", dout4, 8'h3C); chk("d4_pp_en", en4, 1);
    w4 = 0;
    tick();
    chk("d4_drain_nd", nd4, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d4_empty_rd_nd", nd4, 0); chk("d4_empty_rd_en", en4, 0);
    end
    r4 = 0; w4 = 1; din4 = 8'h5A;
    tick();
    w4 = 0;
    chk("d4_5a_en", en4, 1); chk("d4_5a_dout", dout4, 8'h5A); chk("d4_5a_nd", nd4, 1);
    r4 = 1;
    tick();
    r4 = 0;
    chk("d4_5a_pop_en", en4, 0);
    // fill to full, a write while full is dropped, then drain in order
    w4 = 1;
    for (int i = 1; i <= 4; i++) begin
      din4 = 8'(i);
      tick();
    end
    chk("d4_full_nd", nd4, 4); chk("d4_full_fn", fn4, 0); chk("d4_full_dout", dout4, 8'h01);
    din4 = 8'hFF;
    tick();
    chk("d4_full_drop_nd", nd4, 4);
    w4 = 0; r4 = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("d4_order", dout4, 32'(i));
      tick();
    end
    r4 = 0;
    chk("d4_drained_en", en4, 0); chk("d4_drained_fn", fn4, 1);

    // DEPTH=1
    wce1 = 1; rce1 = 1; w1 = 1; din1 = 1;
    tick();
    chk("d1_nd", nd1, 1); chk("d1_en", en1, 1); chk("d1_fn", fn1, 0); chk("d1_dout", dout1, 1);
    din1 = 0; r1 = 1;
    tick();
    chk("d1_pop_only_nd", nd1, 0); chk("d1_pop_only_en", en1, 0); chk("d1_pop_only_fn", fn1, 1);
    r1 = 0;
    tick();
    w1 = 0;
    chk("d1_held_nd", nd1, 1); chk("d1_held_dout", dout1, 0); chk("d1_held_fn", fn1, 0);

    // DEPTH=4 randomised scoreboard
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      w4   = 1'($urandom_range(0, 1));
      wce4 = ($urandom_range(0, 3) != 0);
      r4   = 1'($urandom_range(0, 1));
      rce4 = ($urandom_range(0, 3) != 0);
      din4 = 8'($urandom);
      mpush = w4 & wce4 & (q.size() < 4);
      mpop  = r4 & rce4 & (q.size() > 0);
      if (q.size() > 0) chk("rnd_dout", dout4, q[0]);
      tick();
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(din4);
      chk("rnd_nd", nd4, 32'(q.size()));
      chk("rnd_en", en4, (q.size() != 0));
      chk("rnd_fn", fn4, (q.size() != 4));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
